// File: rtl/vram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_arb_pkg
// Description : Shared types, constants and helpers for the VRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_arb_pkg;

  localparam int NUM_PORTS = 3;
  localparam int RAM_AW    = 14;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    STANDBY = 2'd1,
    WAKE    = 2'd2
  } state_t;

  // The RAM macro masks writes per nibble; each byte enable covers two nibbles.
  function automatic logic [3:0] be_to_nibble_mask(input logic [1:0] be);
    return {be[1], be[1], be[0], be[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter_if
// Description : Requester-side bus of the VRAM arbiter: CPU port 0 (R/W),
//               layer fetch port 1 and sprite fetch port 2 (read-only).
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_arbiter_if import vram_arb_pkg::*; ();

  logic              r0_req;
  logic              r0_we;
  logic [RAM_AW-1:0] r0_addr;
  logic [15:0]       r0_wdata;
  logic [1:0]        r0_be;
  logic              r0_ack;
  logic              r0_rvalid;

  logic              r1_req;
  logic [RAM_AW-1:0] r1_addr;
  logic              r1_ack;
  logic              r1_rvalid;

  logic              r2_req;
  logic [RAM_AW-1:0] r2_addr;
  logic              r2_ack;
  logic              r2_rvalid;

  logic [15:0]       rdata;

  // Requesters drive request/address/data and observe grant/return.
  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r0_be,
    output r1_req, r1_addr,
    output r2_req, r2_addr,
    input  r0_ack, r0_rvalid, r1_ack, r1_rvalid, r2_ack, r2_rvalid, rdata
  );

  // The arbiter sees requests and returns grants and read data.
  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_be,
    input  r1_req, r1_addr,
    input  r2_req, r2_addr,
    output r0_ack, r0_rvalid, r1_ack, r1_rvalid, r2_ack, r2_rvalid, rdata
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter3.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter3
// Description : Combinational 3-way round-robin picker. Priority starts at the
//               index after 'last' and wraps 0,1,2.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] grant,
  output logic [1:0] index,
  output logic       any
);

  logic [1:0] p0, p1, p2;

  // Rotate the priority order so the most recently served port is checked last.
  always_comb begin
    case (last)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase

    grant = 3'b000;
    index = last;
    any   = 1'b0;
    if (req[p0]) begin
      grant[p0] = 1'b1;
      index     = p0;
      any       = 1'b1;
    end else if (req[p1]) begin
      grant[p1] = 1'b1;
      index     = p1;
      any       = 1'b1;
    end else if (req[p2]) begin
      grant[p2] = 1'b1;
      index     = p2;
      any       = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Shares one 16K x 16 single-port VRAM between the CPU, layer
//               and sprite fetch ports, one access per clock, with an idle
//               driven standby controller and timed wake sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter import vram_arb_pkg::*; #(
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  vram_arbiter_if.slave     bus,
  output logic [RAM_AW-1:0] ram_ad,
  output logic [15:0]       ram_di,
  output logic [3:0]        ram_maskwe,
  output logic              ram_we,
  output logic              ram_cs,
  output logic              ram_stdby,
  output logic              ram_sleep,
  output logic              ram_pwroff_n,
  input  logic [15:0]       ram_do,
  output logic              standby
);

  localparam int             ICW       = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam logic [ICW-1:0] IDLE_MAX  = ICW'(IDLE_CYCLES);
  localparam logic [ICW-1:0] IDLE_LAST = (IDLE_CYCLES > 0) ? ICW'(IDLE_CYCLES - 1) : '0;
  localparam logic [3:0]     WAKE_LAST = 4'(WAKE_CYCLES - 1);

  state_t                 state;
  logic [ICW-1:0]         idle_cnt;
  logic [3:0]             wake_cnt;
  logic [1:0]             rr_last;
  logic [NUM_PORTS-1:0]   rvalid_q;
  logic [RAM_AW-1:0]      ad_hold;

  logic [NUM_PORTS-1:0]   req_vec;
  logic [NUM_PORTS-1:0]   arb_req;
  logic [NUM_PORTS-1:0]   grant;
  logic [1:0]             grant_idx;
  logic                   grant_any;
  logic                   any_req;
  logic [RAM_AW-1:0]      sel_addr;

  assign req_vec = {bus.r2_req, bus.r1_req, bus.r0_req};
  assign any_req = |req_vec;
  // Grants only exist in ACTIVE and are suppressed while reset is asserted.
  assign arb_req = (state == ACTIVE && !reset) ? req_vec : '0;

  rr_arbiter3 u_rr (
    .req   (arb_req),
    .last  (rr_last),
    .grant (grant),
    .index (grant_idx),
    .any   (grant_any)
  );

  // Address of the granted port; the last driven address is held when idle.
  always_comb begin
    case (grant_idx)
      2'd0:    sel_addr = bus.r0_addr;
      2'd1:    sel_addr = bus.r1_addr;
      default: sel_addr = bus.r2_addr;
    endcase
  end

  assign ram_ad       = grant_any ? sel_addr : ad_hold;
  assign ram_di       = bus.r0_wdata;
  assign ram_cs       = grant_any;
  assign ram_we       = grant[0] & bus.r0_we;
  assign ram_maskwe   = grant_any ? be_to_nibble_mask(bus.r0_be) : 4'b0000;
  assign ram_sleep    = 1'b0;
  assign ram_pwroff_n = 1'b1;

  assign bus.r0_ack    = grant[0];
  assign bus.r1_ack    = grant[1];
  assign bus.r2_ack    = grant[2];
  // A return pending across a reset edge is dropped immediately.
  assign bus.r0_rvalid = rvalid_q[0] & ~reset;
  assign bus.r1_rvalid = rvalid_q[1] & ~reset;
  assign bus.r2_rvalid = rvalid_q[2] & ~reset;
  assign bus.rdata     = ram_do;

  assign standby = (state != ACTIVE);

  // Power state machine, idle/wake counters, round-robin pointer and read return.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACTIVE;
      idle_cnt  <= '0;
      wake_cnt  <= '0;
      rr_last   <= 2'd2;
      rvalid_q  <= '0;
      ram_stdby <= 1'b0;
      ad_hold   <= '0;
    end else begin
      // Writes never produce a read return.
      rvalid_q <= grant & {2'b11, ~bus.r0_we};
      if (grant_any) begin
        rr_last <= grant_idx;
        ad_hold <= sel_addr;
      end

      case (state)
        ACTIVE: begin
          if (any_req) begin
            idle_cnt <= '0;
          end else begin
            if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
            if ((IDLE_CYCLES != 0) && (idle_cnt == IDLE_LAST)) begin
              state     <= STANDBY;
              ram_stdby <= 1'b1;
            end
          end
        end
        STANDBY: begin
          if (any_req) begin
            state     <= WAKE;
            wake_cnt  <= '0;
            ram_stdby <= 1'b0;
          end
        end
        WAKE: begin
          wake_cnt <= wake_cnt + 1'b1;
          if (wake_cnt == WAKE_LAST) begin
            state    <= ACTIVE;
            idle_cnt <= '0;
          end
        end
        default: state <= ACTIVE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Self-checking bench for vram_arbiter with a behavioural RAM,
//               expectation queues and a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] ram_ad;
  logic [15:0] ram_di;
  logic [15:0] ram_do = 16'h0000;
  logic [3:0]  ram_maskwe;
  logic        ram_we, ram_cs, ram_stdby, ram_sleep, ram_pwroff_n, standby;

  vram_arbiter_if bus ();

  vram_arbiter #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .ram_ad       (ram_ad),
    .ram_di       (ram_di),
    .ram_maskwe   (ram_maskwe),
    .ram_we       (ram_we),
    .ram_cs       (ram_cs),
    .ram_stdby    (ram_stdby),
    .ram_sleep    (ram_sleep),
    .ram_pwroff_n (ram_pwroff_n),
    .ram_do       (ram_do),
    .standby      (standby)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: synchronous read, nibble-masked write.
  logic [15:0] mem [16384];
  logic [15:0] bmask;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        bmask = {{4{ram_maskwe[3]}}, {4{ram_maskwe[2]}}, {4{ram_maskwe[1]}}, {4{ram_maskwe[0]}}};
        mem[ram_ad] <= (mem[ram_ad] & ~bmask) | (ram_di & bmask);
      end else begin
        ram_do <= mem[ram_ad];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          port;
    logic [15:0] data;
  } rd_t;

  int  exp_ack[$];
  rd_t exp_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_rd(input int port, input logic [15:0] data);
    rd_t r;
    r.port = port;
    r.data = data;
    exp_rd.push_back(r);
  endtask

  // Monitor: every grant and every read return is matched against the queues.
  logic [2:0] m_acks, m_rv;
  int         m_port;
  rd_t        m_rd;
  always @(negedge clk) begin
    m_acks = {bus.r2_ack, bus.r1_ack, bus.r0_ack};
    m_rv   = {bus.r2_rvalid, bus.r1_rvalid, bus.r0_rvalid};
    if (m_acks != 3'b000) begin
      if (exp_ack.size() == 0) begin
        check("unexpected_ack", 32'(m_acks), 32'd0);
      end else begin
        m_port = exp_ack.pop_front();
        check("ack_port", 32'(m_acks), 32'(3'b001 << m_port));
      end
    end
    if (m_rv != 3'b000) begin
      if (exp_rd.size() == 0) begin
        check("unexpected_rvalid", 32'(m_rv), 32'd0);
      end else begin
        m_rd = exp_rd.pop_front();
        check("rvalid_port", 32'(m_rv), 32'(3'b001 << m_rd.port));
        check("rdata", 32'(bus.rdata), 32'(m_rd.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    bus.r2_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    mem[14'h0010] = 16'h1234;
    mem[14'h0100] = 16'hFFFF;
    mem[14'h0200] = 16'h1111;
    mem[14'h0300] = 16'h2222;

    reset        = 1'b1;
    bus.r0_req   = 1'b1;
    bus.r0_we    = 1'b0;
    bus.r0_addr  = 14'h0010;
    bus.r0_wdata = 16'h0000;
    bus.r0_be    = 2'b11;
    bus.r1_req   = 1'b0;
    bus.r1_addr  = 14'h0200;
    bus.r2_req   = 1'b0;
    bus.r2_addr  = 14'h0300;

    // Reset: request held high must not be granted.
    tick();
    tick();
    @(negedge clk);
    check("rst_r0_ack", 32'(bus.r0_ack), 32'd0);
    check("rst_ram_cs", 32'(ram_cs), 32'd0);
    check("rst_ram_stdby", 32'(ram_stdby), 32'd0);
    check("rst_standby", 32'(standby), 32'd0);
    check("rst_rvalid", 32'({bus.r2_rvalid, bus.r1_rvalid, bus.r0_rvalid}), 32'd0);
    check("ram_sleep", 32'(ram_sleep), 32'd0);
    check("ram_pwroff_n", 32'(ram_pwroff_n), 32'd1);

    // Single read after reset: ack same cycle, data the next.
    tick();
    reset = 1'b0;
    exp_ack.push_back(0);
    push_rd(0, 16'h1234);
    @(negedge clk);
    check("t1_r0_ack", 32'(bus.r0_ack), 32'd1);
    tick();
    drop_all();
    @(negedge clk);
    check("t1_r0_rvalid", 32'(bus.r0_rvalid), 32'd1);

    // Low-byte write over 0xFFFF then read back.
    tick();
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 14'h0100;
    bus.r0_wdata = 16'hABCD; bus.r0_be = 2'b01;
    exp_ack.push_back(0);
    @(negedge clk);
    check("t2_maskwe", 32'(ram_maskwe), 32'h3);
    check("t2_ram_we", 32'(ram_we), 32'd1);
    tick();
    bus.r0_we = 1'b0;
    exp_ack.push_back(0);
    push_rd(0, 16'hFFCD);
    // Zero byte-enable write: granted, nothing changes.
    tick();
    bus.r0_we = 1'b1; bus.r0_addr = 14'h0010; bus.r0_wdata = 16'h0000; bus.r0_be = 2'b00;
    exp_ack.push_back(0);
    @(negedge clk);
    check("t2_be0_maskwe", 32'(ram_maskwe), 32'h0);
    check("t2_be0_cs", 32'(ram_cs), 32'd1);
    tick();
    bus.r0_we = 1'b0; bus.r0_be = 2'b11;
    exp_ack.push_back(0);
    push_rd(0, 16'h1234);
    tick();
    drop_all();

    // Round robin from reset: all three held for six grants.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.r0_req = 1'b1; bus.r0_addr = 14'h0010;
    bus.r1_req = 1'b1; bus.r2_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_ack.push_back(0); push_rd(0, 16'h1234);
      exp_ack.push_back(1); push_rd(1, 16'h1111);
      exp_ack.push_back(2); push_rd(2, 16'h2222);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3_one_ack", 32'($countones({bus.r2_ack, bus.r1_ack, bus.r0_ack})), 32'd1);
      tick();
    end
    drop_all();

    // Idle into standby: ram_stdby rises on the fifth idle cycle.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("t4_stdby_entry", 32'(ram_stdby), (k == 5) ? 32'd1 : 32'd0);
      tick();
    end
    bus.r2_req = 1'b1;
    exp_ack.push_back(2);
    push_rd(2, 16'h2222);
    @(negedge clk);
    check("t4_sb_no_ack", 32'(bus.r2_ack), 32'd0);
    tick();
    @(negedge clk);
    check("t4_wake_stdby", 32'(ram_stdby), 32'd0);
    check("t4_wake_status", 32'(standby), 32'd1);
    check("t4_wake_ack0", 32'(bus.r2_ack), 32'd0);
    tick();
    @(negedge clk);
    check("t4_wake_ack1", 32'(bus.r2_ack), 32'd0);
    tick();
    @(negedge clk);
    check("t4_r2_ack", 32'(bus.r2_ack), 32'd1);
    check("t4_active", 32'(standby), 32'd0);

    // Reset right after an r1 grant drops its return.
    tick();
    bus.r2_req = 1'b0;
    bus.r1_req = 1'b1;
    exp_ack.push_back(1);
    @(negedge clk);
    check("t5_r1_ack", 32'(bus.r1_ack), 32'd1);
    tick();
    bus.r1_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t5_r1_rvalid", 32'(bus.r1_rvalid), 32'd0);
    check("t5_ram_cs", 32'(ram_cs), 32'd0);
    tick();
    reset = 1'b0;
    bus.r0_req = 1'b1; bus.r0_addr = 14'h0010; bus.r1_req = 1'b1;
    exp_ack.push_back(0); push_rd(0, 16'h1234);
    @(negedge clk);
    check("t5_r0_first", 32'({bus.r1_ack, bus.r0_ack}), 32'h1);
    check("t5_active", 32'(standby), 32'd0);
    tick();
    bus.r0_req = 1'b0;
    exp_ack.push_back(1); push_rd(1, 16'h1111);
    tick();
    drop_all();

    // Request arriving exactly on the standby threshold cycle.
    tick();
    tick();
    tick();
    bus.r0_req = 1'b1; bus.r0_addr = 14'h0100;
    exp_ack.push_back(0); push_rd(0, 16'hFFCD);
    @(negedge clk);
    check("t6_r0_ack", 32'(bus.r0_ack), 32'd1);
    check("t6_active", 32'(standby), 32'd0);
    tick();
    drop_all();
    // Idle counter restarted: standby again only after a fresh 4 idle cycles.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("t6_stdby_retime", 32'(ram_stdby), (k == 5) ? 32'd1 : 32'd0);
      tick();
    end

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 20 && (exp_ack.size() != 0 || exp_rd.size() != 0); i++) tick();
    check("drain_ack", 32'(exp_ack.size()), 32'd0);
    check("drain_rd", 32'(exp_rd.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one 16K x 16 single-port VRAM macro between three requesters, granting one access per clock:
  - Port 0: CPU bus, read/write with byte enables.
  - Port 1: layer/composer fetch, read-only.
  - Port 2: sprite fetch, read-only.
- Drives every control pin of the RAM macro directly.
- Includes an idle-driven standby controller with a timed wake sequence.
- Sits between the bus interface, the video fetch units and the spram instance.

Parameters:
- IDLE_CYCLES, 64: consecutive request-free cycles before entering standby. 0 disables standby.
- WAKE_CYCLES, 2: cycles STDBY must be low before the first grant after standby. Legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- r0_req  in  1  port 0 request (level, held until ack)
- r0_we  in  1  port 0 write (1) / read (0)
- r0_addr  in  14  port 0 word address
- r0_wdata  in  16  port 0 write data
- r0_be  in  2  port 0 byte enables: [0] = bits 7:0, [1] = bits 15:8
- r0_ack  out  1  port 0 grant; access is sampled this cycle
- r0_rvalid  out  1  port 0 read data valid on rdata
- r1_req / r1_addr[13:0] / r1_ack / r1_rvalid  in/in/out/out  port 1, read-only
- r2_req / r2_addr[13:0] / r2_ack / r2_rvalid  in/in/out/out  port 2, read-only
- rdata  out  16  shared read data; passthrough of ram_do
- ram_ad  out  14  to RAM AD
- ram_di  out  16  to RAM DI
- ram_maskwe  out  4  to RAM MASKWE (nibble mask)
- ram_we  out  1  to RAM WE
- ram_cs  out  1  to RAM CS
- ram_stdby  out  1  to RAM STDBY
- ram_sleep  out  1  to RAM SLEEP; constant 0
- ram_pwroff_n  out  1  to RAM PWROFF_N; constant 1
- ram_do  in  16  from RAM DO
- standby  out  1  status: state is STANDBY or WAKE

Behaviour:
- Reset values, all synchronous: state=ACTIVE, idle_cnt=0, wake_cnt=0, rr_last=2, all rvalid=0, ram_stdby=0.
  - Because ack/ram_cs/ram_we are combinational from state and req, they are 0 during reset.
- States:
  - ACTIVE: grants are allowed.
  - STANDBY: ram_stdby=1, no grants.
  - WAKE: ram_stdby=0, no grants, wake_cnt counting.
- Arbitration, ACTIVE only, combinational:
  - Round-robin in order 0,1,2, starting after rr_last.
  - At most one ack per cycle.
  - rr_last updates to the granted index at the clock edge.
  - No request: no grant, rr_last unchanged.
- RAM drive on the grant cycle:
  - ram_cs=1, ram_ad = granted address.
  - ram_we = r0_we only when port 0 is granted, else 0.
  - ram_di = r0_wdata.
  - ram_maskwe = {be[1],be[1],be[0],be[0]}.
  - No grant: ram_cs=0, ram_we=0, ram_maskwe=0. ram_ad/ram_di are don't-care but held stable.
- Read latency: a read acked in cycle N gives rX_rvalid=1 in cycle N+1 only (registered), with rdata=ram_do in N+1.
  - Writes never raise rvalid.
  - Back-to-back reads from different ports pipeline at one access per cycle.
- A write with r0_be=0 is acked and consumes a slot, but no bits change.
- Idle counter, ACTIVE:
  - Any req high: idle_cnt=0.
  - Else idle_cnt increments, saturating at IDLE_CYCLES.
  - When idle_cnt==IDLE_CYCLES-1 and no req is high: next state STANDBY.
  - A request in the same cycle as the threshold keeps ACTIVE and grants normally.
- STANDBY: any req high -> WAKE, wake_cnt=0. Requests stay pending with no ack.
- WAKE:
  - wake_cnt increments each cycle.
  - At wake_cnt==WAKE_CYCLES-1 -> ACTIVE, idle_cnt=0.
  - The first grant occurs in the first ACTIVE cycle, even if requests drop during WAKE.
- IDLE_CYCLES=0: never leave ACTIVE.
- Reset mid-operation: a pending rvalid is dropped, all state returns to reset values, and the requester must re-issue.

Decomposition:
- Package vram_arb_pkg:
  - state enum {ACTIVE, STANDBY, WAKE}.
  - Constants NUM_PORTS=3 and RAM_AW=14.
  - Function be_to_nibble_mask.
- One natural sub-module: rr_arbiter3 (3-way round-robin: req[2:0], last[1:0] -> grant one-hot, index).

Test Plan:
- After reset, r0 read addr 0x0010 holding 0x1234 -> r0_ack same cycle; next cycle r0_rvalid=1, rdata=0x1234; r1/r2 rvalid stay 0.
- r0 write addr 0x0100, wdata 0xABCD, be=2'b01 over old 0xFFFF, then read -> ram_maskwe=4'b0011; readback 0xFFCD.
- r0, r1, r2 held high for 6 cycles -> ack order 0,1,2,0,1,2; exactly one ack per cycle; each rvalid one cycle after its ack.
- IDLE_CYCLES=4, WAKE_CYCLES=2, no requests -> ram_stdby=1 from cycle 5. Then r2_req raised -> ram_stdby=0 next cycle, r2_ack 2 cycles later, r2_rvalid the following cycle.
- r1 read acked in cycle N, reset asserted in cycle N+1 -> r1_rvalid=0 in N+1; state ACTIVE, rr_last=2; next simultaneous r0/r1 request grants r0 first.
- IDLE_CYCLES=4, r0_req first raised exactly on the threshold cycle -> no standby entry, r0_ack that cycle, idle_cnt=0.
